// File: rtl/counter_pkg.sv
// Shared types for the programmable up/down counter family.
//   mode_e  : counting behaviour at the MAX_VAL / 0 boundaries
//   state_e : counter FSM states (COUNT runs, HALT freezes after a one-shot terminal)
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_HALT  = 1'b1
  } state_e;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count calculator.
// Ports:
//   c_in         current count (always <= MAX_VAL)
//   s_in         effective step, already clamped to MAX_VAL
//   up_in        1 = count up, 0 = count down
//   mode_in      boundary behaviour (reserved mode behaves as WRAP)
//   next_out     candidate next count
//   ovf_out      upward crossing of MAX_VAL
//   unf_out      downward crossing of 0
//   halt_req_out one-shot terminal reached, FSM should enter HALT
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic             up_in,
  input  mode_e            mode_in,
  output logic [WIDTH-1:0] next_out,
  output logic             ovf_out,
  output logic             unf_out,
  output logic             halt_req_out
);

  // One extra bit so neither c+s nor c+(MAX_VAL+1) ever truncates.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

  logic [WIDTH:0] c_x;
  logic [WIDTH:0] s_x;
  logic [WIDTH:0] sum_x;

  always_comb begin
    c_x          = {1'b0, c_in};
    s_x          = {1'b0, s_in};
    sum_x        = c_x + s_x;
    next_out     = c_in;
    ovf_out      = 1'b0;
    unf_out      = 1'b0;
    halt_req_out = 1'b0;

    if (up_in) begin
      // Landing exactly on MAX_VAL is not a crossing.
      if (sum_x > MAX_X) begin
        ovf_out = 1'b1;
        case (mode_in)
          MODE_SAT:     next_out = MAX_L;
          MODE_ONESHOT: begin
            next_out     = MAX_L;
            halt_req_out = 1'b1;
          end
          default:      next_out = WIDTH'(sum_x - MOD_X);
        endcase
      end else begin
        next_out = WIDTH'(sum_x);
      end
    end else begin
      // Landing exactly on 0 is not a crossing.
      if (c_x < s_x) begin
        unf_out = 1'b1;
        case (mode_in)
          MODE_SAT:     next_out = '0;
          MODE_ONESHOT: begin
            next_out     = '0;
            halt_req_out = 1'b1;
          end
          default:      next_out = WIDTH'(c_x + MOD_X - s_x);
        endcase
      end else begin
        next_out = WIDTH'(c_x - s_x);
      end
    end
  end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with modulo limit, programmable step,
// wrap / saturate / one-shot modes, overflow/underflow pulses and compare match.
// Ports:
//   clk_in       clock, rising edge
//   rst_in       asynchronous active-low reset
//   en_ctrl_in   count enable
//   set_ctrl_in  synchronous load of load_val_in (wins over enable)
//   up_ctrl_in   1 = up, 0 = down
//   mode_in      00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved (= WRAP)
//   step_in      step magnitude (clamped to MAX_VAL)
//   load_val_in  load value (clamped to MAX_VAL)
//   cmp_val_in   compare value
//   counter_out  registered count
//   ovf_out      registered 1-cycle pulse on upward crossing of MAX_VAL
//   unf_out      registered 1-cycle pulse on downward crossing of 0
//   done_out     registered, high while the FSM is in HALT
//   match_out    combinational counter_out == cmp_val_in
module prog_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int STEP_W    = 4,
  parameter int RESET_VAL = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_ctrl_in,
  input  logic              set_ctrl_in,
  input  logic              up_ctrl_in,
  input  logic [1:0]        mode_in,
  input  logic [STEP_W-1:0] step_in,
  input  logic [WIDTH-1:0]  load_val_in,
  input  logic [WIDTH-1:0]  cmp_val_in,
  output logic [WIDTH-1:0]  counter_out,
  output logic              ovf_out,
  output logic              unf_out,
  output logic              done_out,
  output logic              match_out
);

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_L = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             done_q, done_d;
  state_e           state_q, state_d;

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH-1:0] calc_next;
  logic             calc_ovf;
  logic             calc_unf;
  logic             calc_halt;

  // Clamp step and load value to the modulo range; compare in 32 bits so
  // STEP_W may be wider or narrower than WIDTH.
  always_comb begin
    s_eff    = (32'(step_in) > 32'(MAX_VAL)) ? MAX_L : WIDTH'(step_in);
    load_eff = (load_val_in > MAX_L) ? MAX_L : load_val_in;
  end

  counter_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next_calc (
    .c_in         (counter_q),
    .s_in         (s_eff),
    .up_in        (up_ctrl_in),
    .mode_in      (mode_e'(mode_in)),
    .next_out     (calc_next),
    .ovf_out      (calc_ovf),
    .unf_out      (calc_unf),
    .halt_req_out (calc_halt)
  );

  // Priority: set > enable (only while COUNT) > hold. Flags default to 0 so
  // they clear on every edge without a crossing.
  always_comb begin
    counter_d = counter_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    state_d   = state_q;

    if (set_ctrl_in) begin
      counter_d = load_eff;
      state_d   = ST_COUNT;
    end else if (en_ctrl_in && (state_q == ST_COUNT)) begin
      counter_d = calc_next;
      ovf_d     = calc_ovf;
      unf_d     = calc_unf;
      if (calc_halt) begin
        state_d = ST_HALT;
      end
    end

    done_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      counter_q <= RST_L;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      done_q    <= 1'b0;
      state_q   <= ST_COUNT;
    end else begin
      counter_q <= counter_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      done_q    <= done_d;
      state_q   <= state_d;
    end
  end

  assign counter_out = counter_q;
  assign ovf_out     = ovf_q;
  assign unf_out     = unf_q;
  assign done_out    = done_q;
  assign match_out   = (counter_q == cmp_val_in);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed bench for prog_updown_counter: a table of single-edge vectors on
// the default 8-bit / MAX_VAL=255 instance, plus hand-written sequences for
// reset, a MAX_VAL=9 instance, and HALT recovery.
module tb_prog_updown_counter;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       en_ctrl_in;
  logic       set_ctrl_in;
  logic       up_ctrl_in;
  logic [1:0] mode_in;
  logic [3:0] step_in;
  logic [7:0] load_val_in;
  logic [7:0] cmp_val_in;

  logic [7:0] cnt_a, cnt_b;
  logic       ovf_a, unf_a, done_a, match_a;
  logic       ovf_b, unf_b, done_b, match_b;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk_in = ~clk_in;

  prog_updown_counter dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en_ctrl_in  (en_ctrl_in),
    .set_ctrl_in (set_ctrl_in),
    .up_ctrl_in  (up_ctrl_in),
    .mode_in     (mode_in),
    .step_in     (step_in),
    .load_val_in (load_val_in),
    .cmp_val_in  (cmp_val_in),
    .counter_out (cnt_a),
    .ovf_out     (ovf_a),
    .unf_out     (unf_a),
    .done_out    (done_a),
    .match_out   (match_a)
  );

  prog_updown_counter #(.WIDTH(8), .MAX_VAL(9), .STEP_W(4), .RESET_VAL(0)) dut9 (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en_ctrl_in  (en_ctrl_in),
    .set_ctrl_in (set_ctrl_in),
    .up_ctrl_in  (up_ctrl_in),
    .mode_in     (mode_in),
    .step_in     (step_in),
    .load_val_in (load_val_in),
    .cmp_val_in  (cmp_val_in),
    .counter_out (cnt_b),
    .ovf_out     (ovf_b),
    .unf_out     (unf_b),
    .done_out    (done_b),
    .match_out   (match_b)
  );

  typedef struct {
    logic       set;
    logic       en;
    logic       up;
    logic [1:0] mode;
    logic [3:0] step;
    logic [7:0] load;
    logic [7:0] cmp;
    logic [7:0] cnt;
    logic       ovf;
    logic       unf;
    logic       done;
    logic       match;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic set, logic en, logic up, logic [1:0] mode,
                              logic [3:0] step, logic [7:0] load, logic [7:0] cmp,
                              logic [7:0] cnt, logic ovf, logic unf, logic done,
                              logic match);
    vec_t v;
    v.set = set; v.en = en; v.up = up; v.mode = mode; v.step = step;
    v.load = load; v.cmp = cmp; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    v.done = done; v.match = match;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic set, input logic en, input logic up,
                       input logic [1:0] mode, input logic [3:0] step,
                       input logic [7:0] load, input logic [7:0] cmp);
    set_ctrl_in = set;
    en_ctrl_in  = en;
    up_ctrl_in  = up;
    mode_in     = mode;
    step_in     = step;
    load_val_in = load;
    cmp_val_in  = cmp;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Fields: set en up mode step load cmp | cnt ovf unf done match
    // WRAP up across 0xFF
    vecs[0]  = mk(1, 0, 1, 2'd0, 4'd1, 8'hFE, 8'h00, 8'hFE, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 2'd0, 4'd1, 8'hFE, 8'h00, 8'hFF, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 2'd0, 4'd1, 8'hFE, 8'h00, 8'h00, 1, 0, 0, 1);
    vecs[3]  = mk(0, 1, 1, 2'd0, 4'd1, 8'hFE, 8'h00, 8'h01, 0, 0, 0, 0);
    // SAT up, pulse repeats while pinned, then count down
    vecs[4]  = mk(1, 0, 1, 2'd1, 4'd5, 8'hFC, 8'hFF, 8'hFC, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 1, 2'd1, 4'd5, 8'hFC, 8'hFF, 8'hFF, 1, 0, 0, 1);
    vecs[6]  = mk(0, 1, 1, 2'd1, 4'd5, 8'hFC, 8'hFF, 8'hFF, 1, 0, 0, 1);
    vecs[7]  = mk(0, 1, 0, 2'd1, 4'd5, 8'hFC, 8'hFF, 8'hFA, 0, 0, 0, 0);
    // ONESHOT down into HALT, enable ignored, set releases
    vecs[8]  = mk(1, 0, 0, 2'd2, 4'd2, 8'h03, 8'h00, 8'h03, 0, 0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 2'd2, 4'd2, 8'h03, 8'h00, 8'h01, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 2'd2, 4'd2, 8'h03, 8'h00, 8'h00, 0, 1, 1, 1);
    vecs[11] = mk(0, 1, 0, 2'd2, 4'd2, 8'h03, 8'h00, 8'h00, 0, 0, 1, 1);
    vecs[12] = mk(1, 1, 0, 2'd2, 4'd2, 8'h20, 8'h20, 8'h20, 0, 0, 0, 1);
    // set wins over enable, then match after next count
    vecs[13] = mk(1, 1, 1, 2'd0, 4'd1, 8'h80, 8'h81, 8'h80, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 1, 2'd0, 4'd1, 8'h80, 8'h81, 8'h81, 0, 0, 0, 1);
    // landing exactly on 0 is not a crossing; step 0 holds
    vecs[15] = mk(1, 0, 0, 2'd0, 4'd5, 8'h05, 8'h00, 8'h05, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 2'd0, 4'd5, 8'h05, 8'h00, 8'h00, 0, 0, 0, 1);
    vecs[17] = mk(0, 1, 0, 2'd0, 4'd0, 8'h05, 8'h00, 8'h00, 0, 0, 0, 1);
    // reserved mode behaves as WRAP in both directions
    vecs[18] = mk(0, 1, 0, 2'd3, 4'd1, 8'h05, 8'hFF, 8'hFF, 0, 1, 0, 1);
    vecs[19] = mk(0, 1, 1, 2'd3, 4'd1, 8'h05, 8'hFF, 8'h00, 1, 0, 0, 0);
    // enable low holds and clears flags
    vecs[20] = mk(0, 0, 1, 2'd3, 4'd1, 8'h05, 8'h00, 8'h00, 0, 0, 0, 1);

    drive(0, 0, 1, 2'd0, 4'd0, 8'h00, 8'h00);
    rst_in = 1'b0;
    #2;
    chk("reset_cnt",  {24'd0, cnt_a}, 32'h00);
    chk("reset_ovf",  {31'd0, ovf_a}, 32'd0);
    chk("reset_unf",  {31'd0, unf_a}, 32'd0);
    chk("reset_done", {31'd0, done_a}, 32'd0);
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].set, vecs[i].en, vecs[i].up, vecs[i].mode, vecs[i].step,
            vecs[i].load, vecs[i].cmp);
      tick();
      chk($sformatf("v%0d_cnt", i),   {24'd0, cnt_a},   {24'd0, vecs[i].cnt});
      chk($sformatf("v%0d_ovf", i),   {31'd0, ovf_a},   {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d_unf", i),   {31'd0, unf_a},   {31'd0, vecs[i].unf});
      chk($sformatf("v%0d_done", i),  {31'd0, done_a},  {31'd0, vecs[i].done});
      chk($sformatf("v%0d_match", i), {31'd0, match_a}, {31'd0, vecs[i].match});
    end

    // MAX_VAL=9 instance: modulo-10 wrap down, 1 - 3 = -2 -> 8, then 5.
    drive(1, 0, 0, 2'd0, 4'd3, 8'h01, 8'h00);
    tick();
    chk("m9_load", {24'd0, cnt_b}, 32'd1);
    drive(0, 1, 0, 2'd0, 4'd3, 8'h01, 8'h00);
    tick();
    chk("m9_wrapdn_cnt", {24'd0, cnt_b}, 32'd8);
    chk("m9_wrapdn_unf", {31'd0, unf_b}, 32'd1);
    tick();
    chk("m9_dn2_cnt", {24'd0, cnt_b}, 32'd5);
    chk("m9_dn2_unf", {31'd0, unf_b}, 32'd0);
    // Load above MAX_VAL clamps to 9; step 15 clamps to 9: 9+9-10 = 8 with ovf.
    drive(1, 0, 1, 2'd0, 4'd15, 8'hFF, 8'h00);
    tick();
    chk("m9_loadclamp", {24'd0, cnt_b}, 32'd9);
    drive(0, 1, 1, 2'd0, 4'd15, 8'hFF, 8'h00);
    tick();
    chk("m9_stepclamp_cnt", {24'd0, cnt_b}, 32'd8);
    chk("m9_stepclamp_ovf", {31'd0, ovf_b}, 32'd1);

    // Asynchronous reset mid-count at 0x37, observed before any edge.
    drive(1, 0, 1, 2'd0, 4'd1, 8'h35, 8'h00);
    tick();
    drive(0, 1, 1, 2'd0, 4'd1, 8'h35, 8'h00);
    tick();
    tick();
    chk("pre_rst_cnt", {24'd0, cnt_a}, 32'h37);
    #2 rst_in = 1'b0;
    #1;
    chk("async_rst_cnt", {24'd0, cnt_a}, 32'h00);
    chk("async_rst_ovf", {31'd0, ovf_a}, 32'd0);
    chk("async_rst_unf", {31'd0, unf_a}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Reset overrides HALT: ONESHOT down from 1 step 2 -> 0, unf, done.
    drive(1, 0, 0, 2'd2, 4'd2, 8'h01, 8'h00);
    tick();
    drive(0, 1, 0, 2'd2, 4'd2, 8'h01, 8'h00);
    tick();
    chk("halt_done", {31'd0, done_a}, 32'd1);
    chk("halt_unf",  {31'd0, unf_a},  32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("halt_rst_done", {31'd0, done_a}, 32'd0);
    chk("halt_rst_unf",  {31'd0, unf_a},  32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    drive(0, 1, 1, 2'd2, 4'd1, 8'h00, 8'h00);
    tick();
    chk("post_rst_count", {24'd0, cnt_a}, 32'h01);
    chk("post_rst_done",  {31'd0, done_a}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
